// File: rtl/msx_mapper_bank_pkg.sv
// Shared mapper definitions for the cartridge bank-switch engine: mapper codes,
// page geometry and the per-mapper power-on bank values.
package msx_mapper_bank_pkg;

  typedef enum logic [2:0] {
    MAPPER_NONE       = 3'd0,
    MAPPER_LINEAR     = 3'd1,
    MAPPER_ASCII8     = 3'd2,
    MAPPER_ASCII16    = 3'd3,
    MAPPER_KONAMI     = 3'd4,
    MAPPER_KONAMI_SCC = 3'd5
  } mapper_typ_t;

  localparam logic [15:0] MAPPER_PAGE_BASE = 16'h4000;
  localparam int          MAPPER_PAGE_SIZE = 8192;

  function automatic int mapper_default_bank(mapper_typ_t mapper, int idx);
    if (mapper == MAPPER_KONAMI || mapper == MAPPER_KONAMI_SCC) return idx;
    return 0;
  endfunction

endpackage

// File: rtl/msx_mapper_wdec.sv
// Combinational write decoder: maps a Z80 write address to the bank registers
// it updates for the active mapper, plus the ASCII16 paired-write flag.
module msx_mapper_wdec
  import msx_mapper_bank_pkg::*;
#(
  parameter int NUM_PAGES = 4
) (
  input  mapper_typ_t          i_mapper,
  input  logic [15:11]         i_cpu_addr,
  output logic [NUM_PAGES-1:0] o_we,
  output logic                 o_pair
);

  logic [2:0] w_region;
  logic [1:0] w_page;
  logic [1:0] w_sub;

  assign w_region = i_cpu_addr[15:13];
  assign w_sub    = i_cpu_addr[12:11];
  // Page index is region - 2 for regions 2..5
  assign w_page   = {~i_cpu_addr[14], i_cpu_addr[13]};

  always_comb begin
    o_we   = '0;
    o_pair = 1'b0;
    case (i_mapper)
      MAPPER_ASCII8: begin
        if (w_region == 3'd3)
          for (int i = 0; i < NUM_PAGES; i++)
            if (w_sub == 2'(i)) o_we[i] = 1'b1;
      end
      MAPPER_ASCII16: begin
        o_pair = 1'b1;
        if (i_cpu_addr[15:11] == 5'b01100) o_we[1:0] = 2'b11;
        if (i_cpu_addr[15:11] == 5'b01110) o_we[3:2] = 2'b11;
      end
      MAPPER_KONAMI: begin
        if (w_region >= 3'd3 && w_region <= 3'd5)
          for (int i = 0; i < NUM_PAGES; i++)
            if (w_page == 2'(i)) o_we[i] = 1'b1;
      end
      MAPPER_KONAMI_SCC: begin
        if (w_region >= 3'd2 && w_region <= 3'd5 && w_sub == 2'b10)
          for (int i = 0; i < NUM_PAGES; i++)
            if (w_page == 2'(i)) o_we[i] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/msx_mapper_bank.sv
// Cartridge bank-switch engine: per-page bank registers and 1-cycle read translation
// into ROM image offsets. Optional battery SRAM pages are enabled by MAPPER_SRAM_EN.
module msx_mapper_bank
  import msx_mapper_bank_pkg::*;
#(
  parameter int NUM_PAGES   = 4,
  parameter int BANK_W      = 8,
  parameter int ADDR_W      = 25,
  parameter int SRAM_ADDR_W = 13
) (
  input  logic                   clk,
  input  logic                   reset,
  input  mapper_typ_t            mapper,
  input  logic [BANK_W:0]        rom_mask,
  input  logic                   cs,
  input  logic [15:0]            cpu_addr,
  input  logic [7:0]             cpu_dout,
  input  logic                   cpu_wr,
  input  logic                   cpu_rd,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_oe,
  output logic                   scc_sel,
  output logic                   sram_sel,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic                   sram_we
);

  localparam logic [16:0] WIN_END = 17'(MAPPER_PAGE_BASE) + 17'(NUM_PAGES * MAPPER_PAGE_SIZE);

  logic [BANK_W-1:0]    r_bank [NUM_PAGES];
  mapper_typ_t          r_mapper_q;
  logic [NUM_PAGES-1:0] w_we;
  logic                 w_pair;
  logic                 w_in_win;
  logic                 w_chg;
  logic                 w_scc;
  logic                 w_sram_pg;
  logic                 w_rd_ok;
  logic [1:0]           w_page;
  logic [BANK_W-1:0]    w_bank_sel;
  logic [BANK_W-1:0]    w_bank_eff;
  logic [BANK_W:0]      w_rom_bank;
`ifdef MAPPER_SRAM_EN
  logic                 w_ascii;
  logic                 w_sram_rd;
  logic                 w_sram_wr;
`endif

  if (ADDR_W < BANK_W + 14) begin : g_chk_addr_w
    $error("msx_mapper_bank: ADDR_W must be at least BANK_W + 14");
  end
  if (NUM_PAGES != 4) begin : g_chk_pages
    $error("msx_mapper_bank: NUM_PAGES must be 4");
  end

  msx_mapper_wdec #(.NUM_PAGES(NUM_PAGES)) u_wdec (
    .i_mapper   (r_mapper_q),
    .i_cpu_addr (cpu_addr[15:11]),
    .o_we       (w_we),
    .o_pair     (w_pair)
  );

  assign w_in_win = (cpu_addr >= MAPPER_PAGE_BASE) && ({1'b0, cpu_addr} < WIN_END);
  assign w_page   = {~cpu_addr[14], cpu_addr[13]};
  assign w_chg    = (mapper != r_mapper_q);
  assign w_scc    = cs && (cpu_rd || cpu_wr) && (r_mapper_q == MAPPER_KONAMI_SCC) &&
                    (r_bank[2][5:0] == 6'h3F) && (cpu_addr[15:11] == 5'b10011);

  always_comb begin
    w_bank_sel = r_bank[w_page];
    w_bank_eff = w_bank_sel;
    // Mapperless images sit linearly from 0x4000, so the page number is the bank
    if (r_mapper_q == MAPPER_NONE || r_mapper_q == MAPPER_LINEAR)
      w_bank_eff = BANK_W'(w_page);
`ifdef MAPPER_SRAM_EN
    if (w_ascii) w_bank_eff[BANK_W-1] = 1'b0;
`endif
  end

  assign w_rom_bank = {1'b0, w_bank_eff} & rom_mask;
  assign w_rd_ok    = cs && cpu_rd && w_in_win && !w_scc && !w_sram_pg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mapper_q <= mapper;
      for (int i = 0; i < NUM_PAGES; i++)
        r_bank[i] <= BANK_W'(mapper_default_bank(mapper, i));
      mem_addr <= '0;
      mem_oe   <= 1'b0;
      scc_sel  <= 1'b0;
    end else begin
      mem_oe  <= w_rd_ok;
      scc_sel <= w_scc;
      if (w_rd_ok) mem_addr <= ADDR_W'({w_rom_bank, cpu_addr[12:0]});
      // A mapper change reloads every bank and swallows a coincident write
      if (w_chg) begin
        r_mapper_q <= mapper;
        for (int i = 0; i < NUM_PAGES; i++)
          r_bank[i] <= BANK_W'(mapper_default_bank(mapper, i));
      end else if (cs && cpu_wr) begin
        for (int i = 0; i < NUM_PAGES; i++)
          if (w_we[i])
            r_bank[i] <= w_pair ? (BANK_W'({cpu_dout, 1'b0}) | BANK_W'(i % 2))
                                : BANK_W'(cpu_dout);
      end
    end
  end

`ifdef MAPPER_SRAM_EN
  assign w_ascii   = (r_mapper_q == MAPPER_ASCII8) || (r_mapper_q == MAPPER_ASCII16);
  assign w_sram_pg = w_ascii && w_in_win && w_bank_sel[BANK_W-1];
  assign w_sram_rd = cs && cpu_rd && w_sram_pg;
  assign w_sram_wr = cs && cpu_wr && w_sram_pg && cpu_addr[15] && !w_chg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sram_sel  <= 1'b0;
      sram_we   <= 1'b0;
      sram_addr <= '0;
    end else begin
      sram_sel <= w_sram_rd || w_sram_wr;
      sram_we  <= w_sram_wr;
      if (w_sram_rd || w_sram_wr) sram_addr <= cpu_addr[SRAM_ADDR_W-1:0];
    end
  end
`else
  assign w_sram_pg = 1'b0;
  assign sram_sel  = 1'b0;
  assign sram_we   = 1'b0;
  assign sram_addr = '0;
`endif

endmodule

// File: tb/tb_msx_mapper_bank.sv
// Self-checking bench for msx_mapper_bank: directed scenarios followed by random
// traffic, all checked against an arithmetic model of the mapper rules.
module tb_msx_mapper_bank;
  import msx_mapper_bank_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  mapper_typ_t mapper;
  logic [8:0]  rom_mask;
  logic        cs;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_wr, cpu_rd;
  logic [24:0] mem_addr;
  logic        mem_oe, scc_sel, sram_sel, sram_we;
  logic [12:0] sram_addr;

  int n_cmp  = 0;
  int n_fail = 0;

  int m_bank[4];
  int m_mq;
  int e_addr, e_saddr;
  bit e_oe, e_scc, e_ssel, e_swe;
  logic [8:0] masks[5] = '{9'h003, 9'h00F, 9'h01F, 9'h0FF, 9'h1FF};

`ifdef MAPPER_SRAM_EN
  localparam bit SRAM_EN = 1'b1;
`else
  localparam bit SRAM_EN = 1'b0;
`endif

  msx_mapper_bank dut (
    .clk       (clk),
    .reset     (reset),
    .mapper    (mapper),
    .rom_mask  (rom_mask),
    .cs        (cs),
    .cpu_addr  (cpu_addr),
    .cpu_dout  (cpu_dout),
    .cpu_wr    (cpu_wr),
    .cpu_rd    (cpu_rd),
    .mem_addr  (mem_addr),
    .mem_oe    (mem_oe),
    .scc_sel   (scc_sel),
    .sram_sel  (sram_sel),
    .sram_addr (sram_addr),
    .sram_we   (sram_we)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_defaults();
    for (int i = 0; i < 4; i++)
      m_bank[i] = (m_mq == int'(MAPPER_KONAMI) || m_mq == int'(MAPPER_KONAMI_SCC)) ? i : 0;
  endtask

  task automatic model_reset();
    m_mq = int'(mapper);
    model_defaults();
    e_addr = 0; e_saddr = 0;
    e_oe = 0; e_scc = 0; e_ssel = 0; e_swe = 0;
  endtask

  // Evaluates one access against the pre-edge model state and advances it
  task automatic model_cycle(input bit w, input bit r, input int a, input int d);
    int p, b, off;
    bit inwin, scc, ascii, spg, chg;
    inwin = (a >= 'h4000) && (a <= 'hBFFF);
    p     = inwin ? (a - 'h4000) / 'h2000 : 0;
    off   = a % 'h2000;
    chg   = (int'(mapper) != m_mq);
    ascii = (m_mq == int'(MAPPER_ASCII8)) || (m_mq == int'(MAPPER_ASCII16));
    scc   = cs && (w || r) && (m_mq == int'(MAPPER_KONAMI_SCC)) &&
            ((m_bank[2] % 64) == 63) && (a >= 'h9800) && (a <= 'h9FFF);
    spg   = SRAM_EN && ascii && inwin && (m_bank[p] >= 128);
    b     = (m_mq == int'(MAPPER_NONE) || m_mq == int'(MAPPER_LINEAR)) ? p : m_bank[p];
    if (SRAM_EN && ascii) b = b % 128;
    b     = b & int'(rom_mask);
    e_oe  = cs && r && inwin && !scc && !spg;
    if (e_oe) e_addr = b * 'h2000 + off;
    e_scc  = scc;
    e_swe  = cs && w && spg && (a >= 'h8000) && !chg;
    e_ssel = (cs && r && spg) || e_swe;
    if (e_ssel) e_saddr = off;
    if (chg) begin
      m_mq = int'(mapper);
      model_defaults();
    end else if (cs && w) begin
      case (m_mq)
        int'(MAPPER_ASCII8):
          if (a >= 'h6000 && a <= 'h7FFF) m_bank[(a - 'h6000) / 'h800] = d;
        int'(MAPPER_ASCII16):
          if (a >= 'h6000 && a <= 'h67FF) begin
            m_bank[0] = (2 * d) % 256; m_bank[1] = (2 * d + 1) % 256;
          end else if (a >= 'h7000 && a <= 'h77FF) begin
            m_bank[2] = (2 * d) % 256; m_bank[3] = (2 * d + 1) % 256;
          end
        int'(MAPPER_KONAMI):
          if (a >= 'h6000 && a <= 'hBFFF) m_bank[p] = d;
        int'(MAPPER_KONAMI_SCC):
          if (inwin && off >= 'h1000 && off <= 'h17FF) m_bank[p] = d;
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    chk("mem_oe",    32'(mem_oe),    32'(e_oe));
    chk("mem_addr",  32'(mem_addr),  32'(e_addr));
    chk("scc_sel",   32'(scc_sel),   32'(e_scc));
    chk("sram_sel",  32'(sram_sel),  32'(e_ssel));
    chk("sram_we",   32'(sram_we),   32'(e_swe));
    chk("sram_addr", 32'(sram_addr), 32'(e_saddr));
  endtask

  task automatic cyc(input bit w, input bit r, input logic [15:0] a, input logic [7:0] d);
    cpu_wr = w; cpu_rd = r; cpu_addr = a; cpu_dout = d;
    model_cycle(w, r, int'(a), int'(d));
    @(posedge clk); #1;
    cpu_wr = 1'b0; cpu_rd = 1'b0;
    check_all();
  endtask

  initial begin
    reset = 1'b1; mapper = MAPPER_KONAMI; rom_mask = 9'h1FF; cs = 1'b0;
    cpu_addr = '0; cpu_dout = '0; cpu_wr = 1'b0; cpu_rd = 1'b0;
    @(posedge clk); #1;
    model_reset();
    check_all();
    chk("reset_oe",   32'(mem_oe),   32'h0);
    chk("reset_addr", 32'(mem_addr), 32'h0);
    reset = 1'b0;
    cs = 1'b1;

    // KONAMI power-on banks
    cyc(0, 1, 16'h8123, 8'h00);
    chk("konami_oe",   32'(mem_oe),   32'h1);
    chk("konami_addr", 32'(mem_addr), 32'h4123);

    // ASCII8 write and rom_mask wrap
    mapper = MAPPER_ASCII8; cyc(0, 0, 16'h0000, 8'h00);
    cyc(1, 0, 16'h7000, 8'h05);
    cyc(0, 1, 16'h8010, 8'h00);
    chk("ascii8_addr", 32'(mem_addr), 32'hA010);
    rom_mask = 9'h003;
    cyc(0, 1, 16'h8010, 8'h00);
    chk("ascii8_mask", 32'(mem_addr), 32'h2010);
    rom_mask = 9'h00F;
    cyc(1, 0, 16'h6000, 8'h13);
    cyc(0, 1, 16'h4000, 8'h00);
    chk("ascii8_wrap", 32'(mem_addr), 32'h6000);
    rom_mask = 9'h1FF;

    // ASCII16 paired write
    mapper = MAPPER_ASCII16; cyc(0, 0, 16'h0000, 8'h00);
    cyc(1, 0, 16'h7000, 8'h03);
    cyc(0, 1, 16'hA000, 8'h00);
    chk("ascii16_addr", 32'(mem_addr), 32'hE000);

    // KONAMI_SCC register window
    mapper = MAPPER_KONAMI_SCC; cyc(0, 0, 16'h0000, 8'h00);
    cyc(1, 0, 16'h9000, 8'h3F);
    cyc(0, 1, 16'h9800, 8'h00);
    chk("scc_sel_on", 32'(scc_sel), 32'h1);
    chk("scc_oe_off", 32'(mem_oe),  32'h0);
    cyc(1, 0, 16'h9000, 8'h3E);
    cyc(0, 1, 16'h9800, 8'h00);
    chk("scc_sel_off", 32'(scc_sel),  32'h0);
    chk("scc_rom_oe",  32'(mem_oe),   32'h1);
    chk("scc_rom_adr", 32'(mem_addr), 32'h7D800);

    // LINEAR maps the image straight from 0x4000
    mapper = MAPPER_LINEAR; cyc(0, 0, 16'h0000, 8'h00);
    cyc(0, 1, 16'hA123, 8'h00);
    chk("linear_addr", 32'(mem_addr), 32'h6123);

    // Mapper change beats a coincident write
    mapper = MAPPER_ASCII8; cyc(0, 0, 16'h0000, 8'h00);
    cyc(1, 0, 16'h6000, 8'h07);
    mapper = MAPPER_KONAMI;
    cyc(1, 0, 16'h6000, 8'h09);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 16'(16'h4000 + i * 16'h2000), 8'h00);
      chk("chg_bank", 32'(mem_addr), 32'(i * 'h2000));
    end

    // Deselected slot is ignored; out-of-window read holds mem_addr
    cs = 1'b0;
    cyc(1, 0, 16'h6000, 8'h05);
    cyc(0, 1, 16'h6000, 8'h00);
    chk("cs0_oe", 32'(mem_oe), 32'h0);
    cs = 1'b1;
    cyc(0, 1, 16'h6000, 8'h00);
    chk("cs0_nowr", 32'(mem_addr), 32'h2000);
    cyc(0, 1, 16'hC000, 8'h00);
    chk("oow_oe",   32'(mem_oe),   32'h0);
    chk("oow_hold", 32'(mem_addr), 32'h2000);

`ifdef MAPPER_SRAM_EN
    mapper = MAPPER_ASCII8; cyc(0, 0, 16'h0000, 8'h00);
    cyc(1, 0, 16'h7000, 8'h80);
    cyc(1, 0, 16'h8004, 8'h55);
    chk("sram_we",   32'(sram_we),   32'h1);
    chk("sram_addr", 32'(sram_addr), 32'h0004);
    chk("sram_oe",   32'(mem_oe),    32'h0);
`endif

    for (int n = 0; n < 3000; n++) begin
      logic [15:0] a;
      logic [7:0]  d;
      int          op;
      if ($urandom_range(0, 31) == 0) mapper = mapper_typ_t'(3'($urandom_range(0, 7)));
      if ($urandom_range(0, 15) == 0) rom_mask = masks[$urandom_range(0, 4)];
      cs = ($urandom_range(0, 7) != 0);
      a  = ($urandom_range(0, 3) == 0) ? 16'($urandom()) : 16'(32'h4000 + $urandom_range(0, 32'h7FFF));
      case ($urandom_range(0, 7))
        0, 1:    d = 8'h3F;
        2:       d = 8'(8'h80 | $urandom_range(0, 127));
        default: d = 8'($urandom_range(0, 255));
      endcase
      op = $urandom_range(0, 2);
      cyc(op == 1, op == 2, a, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/msx_mapper_bank.md
Name: msx_mapper_bank

Overview:
- Parametrised cartridge bank-switch engine for one MSX cartridge slot.
- Decodes Z80 writes into per-page bank registers for the ROM mapper types in the shared package.
- Translates each CPU access in 0x4000–0xBFFF into a linear SDRAM offset, one cycle after the access.
- Sits between the slot decoder and the memory arbiter. It replaces the per-mapper fixed logic with one engine covering NUM_PAGES pages and a configurable bank width.

Parameters:
- NUM_PAGES, 4, number of 8 KB pages handled. Page i covers 0x4000 + i·0x2000; the legal value is 4.
- BANK_W, 8, width of one bank register in 8 KB units.
- ADDR_W, 25, width of mem_addr. Must be ≥ BANK_W + 14; checked by an elaboration assertion.
- SRAM_ADDR_W, 13, width of sram_addr (used only with MAPPER_SRAM_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mapper  in  mapper_typ_t  active mapper; quasi-static
- rom_mask  in  BANK_W+1  (ROM size in 8 KB units) − 1; must be 2^n − 1
- cs  in  1  slot selected for this cartridge
- cpu_addr  in  16  Z80 address
- cpu_dout  in  8  Z80 write data
- cpu_wr  in  1  single-cycle write strobe
- cpu_rd  in  1  single-cycle read strobe
- mem_addr  out  ADDR_W  byte offset into the cartridge ROM image
- mem_oe  out  1  mem_addr is valid for a read this cycle
- scc_sel  out  1  access targets the SCC register window
- sram_sel  out  1  access targets battery SRAM (MAPPER_SRAM_EN only, else 0)
- sram_addr  out  SRAM_ADDR_W  SRAM byte offset
- sram_we  out  1  SRAM write strobe

Behaviour:
- Reset:
  - All outputs 0.
  - Bank registers load the mapper defaults.
  - mapper_q (registered copy of mapper) loads the current mapper value.
- Mapper change:
  - If mapper != mapper_q, all bank registers reload the defaults and mapper_q updates in the same cycle.
  - A CPU write in that same cycle is dropped; the mapper change wins.
- Defaults:
  - MAPPER_KONAMI and MAPPER_KONAMI_SCC: bank[i] = i.
  - All other mappers: 0.
- Write decode (only when cs & cpu_wr; the register updates on the next clk edge):
  - MAPPER_ASCII8: bank[k] ← cpu_dout for writes at 0x6000 + k·0x800 .. +0x7FF, k = 0..3.
  - MAPPER_ASCII16: 0x6000–0x67FF writes pair 0 = {bank0, bank1} ← {2d, 2d+1}. 0x7000–0x77FF writes pair 1 = {bank2, bank3} the same way. d = cpu_dout.
  - MAPPER_KONAMI: 0x6000/0x8000/0xA000 regions (8 KB each) write bank1/2/3. Bank0 is fixed at 0.
  - MAPPER_KONAMI_SCC: 0x5000–0x57FF, 0x7000–0x77FF, 0x9000–0x97FF, 0xB000–0xB7FF write bank0..3.
  - MAPPER_NONE, MAPPER_LINEAR and all other codes: no register writes.
- Read translation (registered, 1-cycle latency):
  - Condition: cs & cpu_rd & 0x4000 ≤ cpu_addr ≤ 0xBFFF. Page p = cpu_addr[15:13] − 2.
  - mem_addr = {(bank[p] & rom_mask), cpu_addr[12:0]}, zero-extended to ADDR_W. mem_oe = 1 for one cycle.
  - MAPPER_NONE and LINEAR use the bank value p instead of bank[p], so the ROM image maps at 0x4000.
  - Access outside the window: mem_oe = 0 and mem_addr holds its previous value.
  - Banks wrap modulo the ROM size through rom_mask. Example: rom_mask = 0x0F with bank 0x13 gives bank 0x03.
- scc_sel:
  - Asserted with the same 1-cycle latency when mapper = KONAMI_SCC, bank2[5:0] = 0x3F and the address is in 0x9800–0x9FFF, for either read or write.
  - mem_oe = 0 while scc_sel is asserted.
- Write or read strobe with cs = 0: ignored completely.

Optional Feature:
- Macro MAPPER_SRAM_EN.
- When defined, for ASCII8 and ASCII16 only:
  - A bank written with bit BANK_W−1 set marks that page as SRAM.
  - Reads in an SRAM page assert sram_sel (not mem_oe), with sram_addr = cpu_addr[SRAM_ADDR_W-1:0].
  - Writes to 0x8000–0xBFFF in an SRAM page pulse sram_sel and sram_we for one cycle and do not alter any bank register.
- When undefined: sram_sel, sram_we and sram_addr are tied to 0, and the full bank value is used as the ROM bank.

Decomposition:
- Shared package:
  - mapper_typ_t, used unchanged.
  - The new constants MAPPER_PAGE_BASE = 16'h4000 and MAPPER_PAGE_SIZE = 8192.
  - A function mapper_default_bank(mapper, idx).
- One combinational sub-module, msx_mapper_wdec:
  - Input: mapper, cpu_addr.
  - Output: per-page write-enable vector and the ASCII16 pair flag.
- The bank registers, translation pipeline and SCC/SRAM selection stay in the top module.

Test Plan:
- Reset with mapper = KONAMI, then read 0x8123 → next cycle mem_oe = 1, mem_addr = 0x4123 (bank2 = 2).
- ASCII8: write 0x05 to 0x7000, then read 0x8010 → mem_addr = 0xA010. Repeat with rom_mask = 0x03 → mem_addr = 0x2010.
- ASCII16: write 0x03 to 0x7000, then read 0xA000 → mem_addr = 0xE000 (bank3 = 7).
- KONAMI_SCC: write 0x3F to 0x9000, then read 0x9800 → scc_sel = 1, mem_oe = 0. Write 0x3E to 0x9000 → the same read gives mem_oe = 1.
- Change mapper from ASCII8 to KONAMI in the same cycle as a write to 0x6000 → the write is dropped and the banks read back as 0,1,2,3.
- With MAPPER_SRAM_EN: ASCII8 write 0x80 to 0x7000, then write 0x55 at 0x8004 → sram_we = 1, sram_addr = 0x0004, mem_oe = 0.
